// File: rtl/opnd_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// opnd_fetch_ctrl_pkg
// Shared encodings for the operand fetch sequencer: operand kinds, memory
// data sizes, FSM states, and the helper that narrows returned memory data
// to the instruction's operand size.
// ---------------------------------------------------------------------------
package opnd_fetch_ctrl_pkg;

    localparam int NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        OPND_KIND_NONE = 2'd0,
        OPND_KIND_REG  = 2'd1,
        OPND_KIND_IMM  = 2'd2,
        OPND_KIND_MEM  = 2'd3
    } opnd_kind_e;

    typedef enum logic [1:0] {
        OPSZ_8  = 2'd0,
        OPSZ_16 = 2'd1,
        OPSZ_32 = 2'd2
    } opnd_size_e;

    typedef enum logic [2:0] {
        OFC_IDLE  = 3'd0,
        OFC_MREQ  = 3'd1,
        OFC_MWAIT = 3'd2,
        OFC_DONE  = 3'd3,
        OFC_DRAIN = 3'd4
    } ofc_state_e;

    // Zero-extend memory data to the operand size. The unused code 2'd3 is
    // treated as a full-width pass-through.
    function automatic logic [31:0] size_mask(input logic [1:0] size,
                                              input logic [31:0] data);
        logic [31:0] res;
        case (size)
            OPSZ_8:  res = {24'd0, data[7:0]};
            OPSZ_16: res = {16'd0, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/opnd_fetch_ctrl_next_mem_slot.sv
// ---------------------------------------------------------------------------
// opnd_fetch_ctrl_next_mem_slot
// Combinational search for the lowest live MEM slot at or above start_idx.
// Ports:
//   kinds     - kind of each of the 3 slots ([i] is slot i)
//   count     - number of live slots (slots with index >= count are skipped)
//   start_idx - lowest slot index considered; 3 means "search nothing"
//   found     - a matching slot exists
//   slot_idx  - index of the lowest matching slot (0 when not found)
// ---------------------------------------------------------------------------
module opnd_fetch_ctrl_next_mem_slot
    import opnd_fetch_ctrl_pkg::*;
(
    input  logic [NUM_SLOTS-1:0][1:0] kinds,
    input  logic [1:0]                count,
    input  logic [1:0]                start_idx,
    output logic                      found,
    output logic [1:0]                slot_idx
);

    logic [NUM_SLOTS-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
            localparam logic [1:0] SLOT = gi[1:0];
            assign hit[gi] = (kinds[gi] == OPND_KIND_MEM) &&
                             (SLOT < count) && (SLOT >= start_idx);
        end
    endgenerate

    always_comb begin
        found    = |hit;
        slot_idx = 2'd0;
        if (hit[0]) begin
            slot_idx = 2'd0;
        end else if (hit[1]) begin
            slot_idx = 2'd1;
        end else if (hit[2]) begin
            slot_idx = 2'd2;
        end
    end

endmodule

// File: rtl/opnd_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// opnd_fetch_ctrl
// Sequencer between operand decode and execute. Latches up to three operand
// descriptors, fetches MEM slots one at a time over a single read port, and
// hands the completed operands to execute with a valid/ready handshake.
// A synchronous flush abandons the instruction, draining any in-flight read.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   flush                         - abandon current instruction
//   in_valid/in_ready             - descriptor handshake (ready only in IDLE)
//   opnd_count, opnd_size         - live slot count, memory data size
//   opndN_kind, opndN_val         - slot kind and value / effective address
//   mem_req_valid/ready/addr      - read request channel
//   mem_rsp_valid/data            - read response (one pulse per request)
//   out_valid/out_ready           - completed operand handshake
//   opndN_r                       - final operand values (0 outside DONE)
// All outputs are registered.
// ---------------------------------------------------------------------------
module opnd_fetch_ctrl
    import opnd_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  opnd_count,
    input  logic [1:0]  opnd_size,
    input  logic [1:0]  opnd0_kind,
    input  logic [1:0]  opnd1_kind,
    input  logic [1:0]  opnd2_kind,
    input  logic [31:0] opnd0_val,
    input  logic [31:0] opnd1_val,
    input  logic [31:0] opnd2_val,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] opnd0_r,
    output logic [31:0] opnd1_r,
    output logic [31:0] opnd2_r
);

    ofc_state_e                   state_q, state_d;
    logic [1:0]                   idx_q, idx_d;
    logic [1:0]                   count_q, count_d;
    logic [1:0]                   size_q, size_d;
    logic [NUM_SLOTS-1:0][1:0]    kind_q, kind_d;
    logic [NUM_SLOTS-1:0][31:0]   val_q, val_d;

    logic                         in_ready_q, in_ready_d;
    logic                         mem_req_valid_q, mem_req_valid_d;
    logic [31:0]                  mem_req_addr_q, mem_req_addr_d;
    logic                         out_valid_q, out_valid_d;
    logic [NUM_SLOTS-1:0][31:0]   opnd_r_q, opnd_r_d;

    // Incoming descriptors with slots beyond opnd_count forced to NONE / 0.
    logic [NUM_SLOTS-1:0][1:0]    in_kind_raw, acc_kind;
    logic [NUM_SLOTS-1:0][31:0]   in_val_raw, acc_val;

    assign in_kind_raw = {opnd2_kind, opnd1_kind, opnd0_kind};
    assign in_val_raw  = {opnd2_val, opnd1_val, opnd0_val};

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_accept
            localparam logic [1:0] SLOT = gi[1:0];
            assign acc_kind[gi] = (SLOT < opnd_count) ? in_kind_raw[gi] : OPND_KIND_NONE;
            assign acc_val[gi]  = (SLOT < opnd_count) ? in_val_raw[gi]  : 32'd0;
        end
    endgenerate

    // One shared scanner: in IDLE it searches the incoming descriptors from
    // slot 0; otherwise it searches the latched slots above the current one.
    logic [NUM_SLOTS-1:0][1:0]    scan_kinds;
    logic [1:0]                   scan_count;
    logic [1:0]                   scan_start;
    logic                         scan_found;
    logic [1:0]                   scan_idx;

    always_comb begin
        if (state_q == OFC_IDLE) begin
            scan_kinds = acc_kind;
            scan_count = opnd_count;
            scan_start = 2'd0;
        end else begin
            scan_kinds = kind_q;
            scan_count = count_q;
            scan_start = idx_q + 2'd1;
        end
    end

    opnd_fetch_ctrl_next_mem_slot u_next_mem_slot (
        .kinds     (scan_kinds),
        .count     (scan_count),
        .start_idx (scan_start),
        .found     (scan_found),
        .slot_idx  (scan_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        size_d  = size_q;
        kind_d  = kind_q;
        val_d   = val_q;

        // Flush takes priority over every other transition in each state.
        case (state_q)
            OFC_IDLE: begin
                if (!flush && in_valid) begin
                    count_d = opnd_count;
                    size_d  = opnd_size;
                    kind_d  = acc_kind;
                    val_d   = acc_val;
                    idx_d   = scan_idx;
                    state_d = scan_found ? OFC_MREQ : OFC_DONE;
                end
            end
            OFC_MREQ: begin
                // A request accepted in the flush cycle still returns data,
                // so it must be drained.
                if (flush) begin
                    state_d = mem_req_ready ? OFC_DRAIN : OFC_IDLE;
                end else if (mem_req_ready) begin
                    state_d = OFC_MWAIT;
                end
            end
            OFC_MWAIT: begin
                if (flush) begin
                    state_d = mem_rsp_valid ? OFC_IDLE : OFC_DRAIN;
                end else if (mem_rsp_valid) begin
                    val_d[idx_q] = size_mask(size_q, mem_rsp_data);
                    if (scan_found) begin
                        idx_d   = scan_idx;
                        state_d = OFC_MREQ;
                    end else begin
                        state_d = OFC_DONE;
                    end
                end
            end
            OFC_DONE: begin
                if (flush || out_ready) begin
                    state_d = OFC_IDLE;
                end
            end
            OFC_DRAIN: begin
                if (mem_rsp_valid) begin
                    state_d = OFC_IDLE;
                end
            end
            default: state_d = OFC_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step
        // with it.
        in_ready_d      = (state_d == OFC_IDLE);
        mem_req_valid_d = (state_d == OFC_MREQ);
        mem_req_addr_d  = (state_d == OFC_MREQ) ? val_d[idx_d] : 32'd0;
        out_valid_d     = (state_d == OFC_DONE);
        opnd_r_d        = (state_d == OFC_DONE) ? val_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= OFC_IDLE;
            idx_q           <= 2'd0;
            count_q         <= 2'd0;
            size_q          <= 2'd0;
            kind_q          <= '0;
            val_q           <= '0;
            in_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= 32'd0;
            out_valid_q     <= 1'b0;
            opnd_r_q        <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            count_q         <= count_d;
            size_q          <= size_d;
            kind_q          <= kind_d;
            val_q           <= val_d;
            in_ready_q      <= in_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            out_valid_q     <= out_valid_d;
            opnd_r_q        <= opnd_r_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign out_valid     = out_valid_q;
    assign opnd0_r       = opnd_r_q[0];
    assign opnd1_r       = opnd_r_q[1];
    assign opnd2_r       = opnd_r_q[2];

endmodule

// File: tb/tb_opnd_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_opnd_fetch_ctrl
// Directed bench for opnd_fetch_ctrl. Inputs change 1 time unit after each
// rising edge; outputs are checked at that same point, away from the edge.
// A monitor records every accepted read request and flags overlapping ones.
// ---------------------------------------------------------------------------
module tb_opnd_fetch_ctrl;
    import opnd_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  opnd_count;
    logic [1:0]  opnd_size;
    logic [1:0]  opnd0_kind, opnd1_kind, opnd2_kind;
    logic [31:0] opnd0_val, opnd1_val, opnd2_val;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opnd0_r, opnd1_r, opnd2_r;

    int n_assert = 0;
    int n_fail   = 0;

    // Request monitor state
    logic [31:0] req_log[$];
    int          outstanding = 0;
    int          overlap_cnt = 0;

    always #5 clk = ~clk;

    opnd_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opnd_count    (opnd_count),
        .opnd_size     (opnd_size),
        .opnd0_kind    (opnd0_kind),
        .opnd1_kind    (opnd1_kind),
        .opnd2_kind    (opnd2_kind),
        .opnd0_val     (opnd0_val),
        .opnd1_val     (opnd1_val),
        .opnd2_val     (opnd2_val),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .opnd0_r       (opnd0_r),
        .opnd1_r       (opnd1_r),
        .opnd2_r       (opnd2_r)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (outstanding != 0) overlap_cnt <= overlap_cnt + 1;
                outstanding <= 1;
                req_log.push_back(mem_req_addr);
            end else if (mem_rsp_valid) begin
                outstanding <= 0;
            end
        end else begin
            outstanding <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] cnt, input logic [1:0] sz,
                        input logic [1:0] k0, input logic [31:0] v0,
                        input logic [1:0] k1, input logic [31:0] v1,
                        input logic [1:0] k2, input logic [31:0] v2);
        in_valid   = 1'b1;
        opnd_count = cnt;
        opnd_size  = sz;
        opnd0_kind = k0; opnd0_val = v0;
        opnd1_kind = k1; opnd1_val = v1;
        opnd2_kind = k2; opnd2_val = v2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
        opnd_count = 2'd0; opnd_size = 2'd0;
        opnd0_kind = 2'd0; opnd1_kind = 2'd0; opnd2_kind = 2'd0;
        opnd0_val = 32'd0; opnd1_val = 32'd0; opnd2_val = 32'd0;

        // ---- reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_opnd0", opnd0_r, 0);
        $display("txn reset done");

        // ---- REG/IMM only, count=2, slot2 beyond count; then backpressure
        load(2'd2, OPSZ_32, OPND_KIND_REG, 32'h11223344, OPND_KIND_IMM, 32'h5,
             OPND_KIND_REG, 32'hFFFFFFFF);
        tick();
        in_valid = 1'b0;
        chk("regimm_out_valid", out_valid, 1);
        chk("regimm_opnd0", opnd0_r, 32'h11223344);
        chk("regimm_opnd1", opnd1_r, 32'h5);
        chk("regimm_opnd2", opnd2_r, 32'h0);
        chk("regimm_no_req", mem_req_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_opnd0", opnd0_r, 32'h11223344);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        $display("txn regimm+backpressure opnd0=%h opnd1=%h", 32'h11223344, 32'h5);

        // ---- single MEM 16-bit, ready stalled 3 cycles, L=2
        load(2'd1, OPSZ_16, OPND_KIND_MEM, 32'h1000, OPND_KIND_NONE, 32'h0,
             OPND_KIND_NONE, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("m16_req_valid", mem_req_valid, 1);
        chk("m16_req_addr", mem_req_addr, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("m16_stall_valid", mem_req_valid, 1);
            chk("m16_stall_addr", mem_req_addr, 32'h1000);
        end
        mem_req_ready = 1'b1;
        tick();                          // handshake
        mem_req_ready = 1'b0;
        chk("m16_wait_req", mem_req_valid, 0);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
        tick();                          // response, L=2
        mem_rsp_valid = 1'b0;
        chk("m16_out_valid", out_valid, 1);
        chk("m16_opnd0", opnd0_r, 32'h0000BEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("m16_idle", in_ready, 1);
        $display("txn mem16 addr=%h opnd0=%h", 32'h1000, opnd0_r);

        // ---- two MEM slots, slot2 MEM beyond count, 32-bit, L=1
        req_log.delete();
        load(2'd2, OPSZ_32, OPND_KIND_MEM, 32'h100, OPND_KIND_MEM, 32'h200,
             OPND_KIND_MEM, 32'h300);
        mem_req_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("m2_req0_addr", mem_req_addr, 32'h100);
        tick();                          // handshake slot0
        chk("m2_wait0_req", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("m2_req1_valid", mem_req_valid, 1);
        chk("m2_req1_addr", mem_req_addr, 32'h200);
        tick();                          // handshake slot1
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("m2_out_valid", out_valid, 1);
        chk("m2_opnd0", opnd0_r, 32'hAAAA5555);
        chk("m2_opnd1", opnd1_r, 32'h12345678);
        chk("m2_opnd2", opnd2_r, 32'h0);
        chk("m2_req_count", req_log.size(), 2);
        chk("m2_log0", (req_log.size() > 0) ? req_log[0] : 32'hX, 32'h100);
        chk("m2_log1", (req_log.size() > 1) ? req_log[1] : 32'hX, 32'h200);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("txn mem2 reqs=%0d", req_log.size());

        // ---- 8-bit MEM in slot1 among REG/IMM, count=3
        load(2'd3, OPSZ_8, OPND_KIND_REG, 32'hCAFEF00D, OPND_KIND_MEM, 32'h80,
             OPND_KIND_IMM, 32'h7);
        mem_req_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("m8_req_addr", mem_req_addr, 32'h80);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("m8_opnd0", opnd0_r, 32'hCAFEF00D);
        chk("m8_opnd1", opnd1_r, 32'h78);
        chk("m8_opnd2", opnd2_r, 32'h7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("txn mem8 opnd1=%h", 32'h78);

        // ---- flush in MWAIT, response 3 cycles after handshake
        load(2'd1, OPSZ_32, OPND_KIND_MEM, 32'h40, OPND_KIND_NONE, 32'h0,
             OPND_KIND_NONE, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();                          // handshake
        mem_req_ready = 1'b0;
        flush = 1'b1;
        tick();                          // MWAIT -> DRAIN
        flush = 1'b0;
        chk("fl_drain_in_ready", in_ready, 0);
        chk("fl_drain_out_valid", out_valid, 0);
        tick();
        chk("fl_drain_in_ready2", in_ready, 0);
        chk("fl_drain_req", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h99999999;
        tick();
        mem_rsp_valid = 1'b0;
        chk("fl_idle_in_ready", in_ready, 1);
        chk("fl_idle_out_valid", out_valid, 0);
        $display("txn flush-mwait drained");

        // ---- flush in MREQ without handshake: straight back to IDLE
        load(2'd1, OPSZ_32, OPND_KIND_MEM, 32'h60, OPND_KIND_NONE, 32'h0,
             OPND_KIND_NONE, 32'h0);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flmreq_in_ready", in_ready, 1);
        chk("flmreq_req", mem_req_valid, 0);
        $display("txn flush-mreq idle");

        // ---- reset mid-MREQ
        load(2'd1, OPSZ_32, OPND_KIND_MEM, 32'h2000, OPND_KIND_NONE, 32'h0,
             OPND_KIND_NONE, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("rmreq_req_valid", mem_req_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmreq_req_valid0", mem_req_valid, 0);
        chk("rmreq_addr0", mem_req_addr, 0);
        chk("rmreq_out_valid", out_valid, 0);
        chk("rmreq_in_ready", in_ready, 1);
        chk("rmreq_opnd0", opnd0_r, 0);
        $display("txn reset-mreq recovered");

        chk("no_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
